// File: rtl/rxuart.sv
// 8N1 UART receiver: double-flop synchronizer, mid-bit sampling from a down-counting baud
// counter, and a registered one-cycle write strobe per received byte.
module rxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  localparam logic [23:0] HalfLoad = (CLOCKS_PER_BAUD / 24'd2) - 24'd1;
  localparam logic [23:0] FullLoad = CLOCKS_PER_BAUD - 24'd1;

  state_e      r_state;
  logic        r_q1;
  logic        r_ck_uart;
  logic [23:0] r_baud_counter;
  logic [2:0]  r_index;
  logic [7:0]  r_shift;
  logic        w_sample;

  assign w_sample = (r_baud_counter == 24'd0) &&
                    ((r_state == StStart) || (r_state == StData) || (r_state == StStop));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_q1           <= 1'b1;
      r_ck_uart      <= 1'b1;
      r_baud_counter <= 24'd0;
      r_index        <= 3'd0;
      r_shift        <= 8'h00;
      o_wr           <= 1'b0;
      o_data         <= 8'h00;
      o_frame_err    <= 1'b0;
    end else begin
      r_q1      <= i_uart_rx;
      r_ck_uart <= r_q1;
      o_wr      <= 1'b0;
      // Free-running down-count that saturates at zero; sample points override with a reload.
      if (r_baud_counter != 24'd0) begin
        r_baud_counter <= r_baud_counter - 24'd1;
      end
      case (r_state)
        StIdle: begin
          if (!r_ck_uart) begin
            r_baud_counter <= HalfLoad;
            r_state        <= StStart;
          end
        end
        StStart: begin
          if (w_sample) begin
            r_baud_counter <= FullLoad;
            if (r_ck_uart) begin
              r_state <= StIdle;
            end else begin
              r_index <= 3'd0;
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_sample) begin
            r_shift        <= {r_ck_uart, r_shift[7:1]};
            r_baud_counter <= FullLoad;
            if (r_index == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_index <= r_index + 3'd1;
            end
          end
        end
        StStop: begin
          if (w_sample) begin
            o_data         <= r_shift;
            o_frame_err    <= !r_ck_uart;
            o_wr           <= 1'b1;
            r_baud_counter <= FullLoad;
            r_state        <= r_ck_uart ? StIdle : StBreak;
          end
        end
        StBreak: begin
          if (r_ck_uart) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rxuart.sv
// Directed bench for rxuart: three instances (8, 101 and default clocks per baud) share clock
// and reset; each has its own serial line and a strobe log recording byte, frame error and cycle.
module tb_rxuart;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx8 = 1'b1, rx101 = 1'b1, rxdef = 1'b1;
  logic wr8, wr101, wrdef;
  logic [7:0] d8, d101, ddef;
  logic fe8, fe101, fedef;

  always #5 clk = ~clk;

  rxuart #(.CLOCKS_PER_BAUD(24'd8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_uart_rx(rx8),
    .o_wr(wr8), .o_data(d8), .o_frame_err(fe8)
  );
  rxuart #(.CLOCKS_PER_BAUD(24'd101)) u_dut101 (
    .i_clk(clk), .i_reset(rst), .i_uart_rx(rx101),
    .o_wr(wr101), .o_data(d101), .o_frame_err(fe101)
  );
  rxuart u_dutdef (
    .i_clk(clk), .i_reset(rst), .i_uart_rx(rxdef),
    .o_wr(wrdef), .o_data(ddef), .o_frame_err(fedef)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int t_start;

  logic [7:0] q8_d[$], q101_d[$], qdef_d[$];
  logic       q8_fe[$], q101_fe[$], qdef_fe[$];
  int         q8_c[$], q101_c[$], qdef_c[$];
  logic prev8 = 1'b0, prev101 = 1'b0, prevdef = 1'b0;
  logic dbl8 = 1'b0, dbl101 = 1'b0, dbldef = 1'b0;

  always @(negedge clk) begin
    if (wr8) begin
      q8_d.push_back(d8); q8_fe.push_back(fe8); q8_c.push_back(cyc);
      if (prev8) dbl8 <= 1'b1;
    end
    if (wr101) begin
      q101_d.push_back(d101); q101_fe.push_back(fe101); q101_c.push_back(cyc);
      if (prev101) dbl101 <= 1'b1;
    end
    if (wrdef) begin
      qdef_d.push_back(ddef); qdef_fe.push_back(fedef); qdef_c.push_back(cyc);
      if (prevdef) dbldef <= 1'b1;
    end
    prev8   <= wr8;
    prev101 <= wr101;
    prevdef <= wrdef;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0: rx8 = v;
      1: rx101 = v;
      default: rxdef = v;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ideal 8N1 frame; returns with the line left at the stop-bit level.
  task automatic send(input int which, input logic [7:0] b, input int cpb, input logic stop_v);
    logic [9:0] frame;
    frame = {stop_v, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      set_line(which, frame[i]);
      wait_cyc(cpb);
    end
  endtask

  // Line falls after edge N; synchronizer puts T at edge N+3. Stop sample is at
  // T + CPB/2 + 9*CPB, and the strobe is seen on the following negedge.
  localparam int Lat8   = 3 + 4 + 72;
  localparam int Lat101 = 3 + 50 + 909;
  localparam int LatDef = 3 + 625 + 11250;

  logic [7:0] hello_exp [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                                 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0A, 8'h0D};
  logic [7:0] hello_b2b [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  initial begin
    string msg;
    string s5;
    int base;
    int t0;
    logic [9:0] fr;

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_wr", {31'd0, wr8}, 32'd0);
    chk("reset_data", {24'd0, d8}, 32'd0);
    chk("reset_fe", {31'd0, fe8}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_cyc(5);

    // Single byte
    send(0, 8'h48, 8, 1'b1);
    t0 = t_start;
    wait_cyc(20);
    chk("single_count", q8_d.size(), 32'd1);
    chk("single_data", {24'd0, q8_d[0]}, 32'h48);
    chk("single_fe", {31'd0, q8_fe[0]}, 32'd0);
    chk("single_time", q8_c[0], t0 + Lat8);

    // Back-to-back "Hello"
    base = q8_d.size();
    s5 = "Hello";
    for (int i = 0; i < 5; i++) begin
      send(0, s5[i], 8, 1'b1);
      if (i == 0) t0 = t_start;
    end
    wait_cyc(20);
    chk("b2b_count", q8_d.size(), base + 5);
    chk("b2b_first_time", q8_c[base], t0 + Lat8);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_data%0d", i), {24'd0, q8_d[base+i]}, {24'd0, hello_b2b[i]});
      chk($sformatf("b2b_fe%0d", i), {31'd0, q8_fe[base+i]}, 32'd0);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), q8_c[base+i] - q8_c[base+i-1], 32'd80);
    end

    // Glitch rejection, then a clean byte proves the receiver is idle again
    base = q8_d.size();
    set_line(0, 1'b0);
    wait_cyc(2);
    set_line(0, 1'b1);
    wait_cyc(200);
    chk("glitch_no_strobe", q8_d.size(), base);
    send(0, 8'h3C, 8, 1'b1);
    t0 = t_start;
    wait_cyc(20);
    chk("glitch_after_count", q8_d.size(), base + 1);
    chk("glitch_after_data", {24'd0, q8_d[base]}, 32'h3C);
    chk("glitch_after_time", q8_c[base], t0 + Lat8);

    // Framing error into a 20-bit-time break
    base = q8_d.size();
    send(0, 8'h00, 8, 1'b0);
    wait_cyc(19 * 8);
    chk("break_count", q8_d.size(), base + 1);
    chk("break_data", {24'd0, q8_d[base]}, 32'h00);
    chk("break_fe", {31'd0, q8_fe[base]}, 32'd1);
    set_line(0, 1'b1);
    wait_cyc(24);
    chk("break_release_count", q8_d.size(), base + 1);
    send(0, 8'h55, 8, 1'b1);
    wait_cyc(20);
    chk("after_break_count", q8_d.size(), base + 2);
    chk("after_break_data", {24'd0, q8_d[base+1]}, 32'h55);
    chk("after_break_fe", {31'd0, q8_fe[base+1]}, 32'd0);

    // Reset after data bit 3 of 0xC3
    base = q8_d.size();
    fr = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_line(0, fr[i]);
      wait_cyc(8);
    end
    rst = 1'b1;
    set_line(0, 1'b1);
    #1;
    chk("midrst_wr", {31'd0, wr8}, 32'd0);
    chk("midrst_data", {24'd0, d8}, 32'd0);
    chk("midrst_fe", {31'd0, fe8}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_data_held", {24'd0, d8}, 32'd0);
    rst = 1'b0;
    wait_cyc(100);
    chk("midrst_no_strobe", q8_d.size(), base);
    send(0, 8'hA5, 8, 1'b1);
    wait_cyc(20);
    chk("post_rst_count", q8_d.size(), base + 1);
    chk("post_rst_data", {24'd0, q8_d[base]}, 32'hA5);
    chk("post_rst_fe", {31'd0, q8_fe[base]}, 32'd0);

    // Full message loopback at 101 clocks per bit (odd divisor)
    msg = "Hello, World! \n\r";
    for (int i = 0; i < 16; i++) begin
      send(1, msg[i], 101, 1'b1);
      if (i == 0) t0 = t_start;
    end
    wait_cyc(200);
    chk("loop_count", q101_d.size(), 32'd16);
    chk("loop_first_time", q101_c[0], t0 + Lat101);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("loop_data%0d", i), {24'd0, q101_d[i]}, {24'd0, hello_exp[i]});
      chk($sformatf("loop_fe%0d", i), {31'd0, q101_fe[i]}, 32'd0);
    end

    // Default divider: one byte with exact strobe timing
    send(2, 8'h48, 1250, 1'b1);
    t0 = t_start;
    wait_cyc(50);
    chk("def_count", qdef_d.size(), 32'd1);
    chk("def_data", {24'd0, qdef_d[0]}, 32'h48);
    chk("def_fe", {31'd0, qdef_fe[0]}, 32'd0);
    chk("def_time", qdef_c[0], t0 + LatDef);

    chk("no_double_strobe8", {31'd0, dbl8}, 32'd0);
    chk("no_double_strobe101", {31'd0, dbl101}, 32'd0);
    chk("no_double_strobedef", {31'd0, dbldef}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
